// File: rtl/perf_fpga_complicated_axi_ctrl_driver.sv
// perf_fpga_complicated_axi_ctrl_driver
//
// AXI4-Lite initiator. It turns a one-at-a-time register command stream
// (req_*) into AXI4-Lite write or read transactions on the axi_ctrl_* master
// port, returns each completion on rsp_*, and keeps completion and error
// counters. At most one transaction is outstanding at a time.
//
// Ports
//   aclk, areset        clock; asynchronous active-high reset
//   req_valid/ready     command handshake; req_wr selects write (1) or read (0)
//   req_addr            byte address, forwarded unmodified
//   req_wdata/wstrb     write payload (ignored for reads)
//   rsp_valid/ready     response handshake
//   rsp_wr              echo of the command direction
//   rsp_data            rdata for reads, 0 for writes
//   rsp_resp            bresp / rresp as received
//   wr_cnt, rd_cnt      completed writes / reads (wrap around)
//   err_cnt             completions whose resp was non-zero
//   cnt_clear           synchronous clear of all counters; wins over an increment
//   axi_ctrl_*          AXI4-Lite master channels AW, W, B, AR, R
module perf_fpga_complicated_axi_ctrl_driver #(
  parameter int unsigned CNT_BITS       = 32,
  parameter int unsigned AXI_ADDR_BITS  = 64,
  parameter int unsigned AXIL_DATA_BITS = 64
) (
  input  logic                        aclk,
  input  logic                        areset,

  // AXI4-Lite master: write address
  output logic [AXI_ADDR_BITS-1:0]    axi_ctrl_awaddr,
  output logic                        axi_ctrl_awvalid,
  input  logic                        axi_ctrl_awready,
  // write data
  output logic [AXIL_DATA_BITS-1:0]   axi_ctrl_wdata,
  output logic [AXIL_DATA_BITS/8-1:0] axi_ctrl_wstrb,
  output logic                        axi_ctrl_wvalid,
  input  logic                        axi_ctrl_wready,
  // write response
  input  logic [1:0]                  axi_ctrl_bresp,
  input  logic                        axi_ctrl_bvalid,
  output logic                        axi_ctrl_bready,
  // read address
  output logic [AXI_ADDR_BITS-1:0]    axi_ctrl_araddr,
  output logic                        axi_ctrl_arvalid,
  input  logic                        axi_ctrl_arready,
  // read data
  input  logic [AXIL_DATA_BITS-1:0]   axi_ctrl_rdata,
  input  logic [1:0]                  axi_ctrl_rresp,
  input  logic                        axi_ctrl_rvalid,
  output logic                        axi_ctrl_rready,

  // command stream
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [AXI_ADDR_BITS-1:0]    req_addr,
  input  logic [AXIL_DATA_BITS-1:0]   req_wdata,
  input  logic [AXIL_DATA_BITS/8-1:0] req_wstrb,

  // response stream
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_wr,
  output logic [AXIL_DATA_BITS-1:0]   rsp_data,
  output logic [1:0]                  rsp_resp,

  // statistics
  output logic [CNT_BITS-1:0]         wr_cnt,
  output logic [CNT_BITS-1:0]         rd_cnt,
  output logic [CNT_BITS-1:0]         err_cnt,
  input  logic                        cnt_clear
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_e;

  state_e                      state_q,     state_d;
  logic [AXI_ADDR_BITS-1:0]    addr_q,      addr_d;
  logic [AXIL_DATA_BITS-1:0]   wdata_q,     wdata_d;
  logic [AXIL_DATA_BITS/8-1:0] wstrb_q,     wstrb_d;
  logic                        awvalid_q,   awvalid_d;
  logic                        wvalid_q,    wvalid_d;
  logic                        arvalid_q,   arvalid_d;
  logic                        bready_q,    bready_d;
  logic                        rready_q,    rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_wr_q,    rsp_wr_d;
  logic [AXIL_DATA_BITS-1:0]   rsp_data_q,  rsp_data_d;
  logic [1:0]                  rsp_resp_q,  rsp_resp_d;
  logic [CNT_BITS-1:0]         wr_cnt_q,    wr_cnt_d;
  logic [CNT_BITS-1:0]         rd_cnt_q,    rd_cnt_d;
  logic [CNT_BITS-1:0]         err_cnt_q,   err_cnt_d;

  logic b_hs;
  logic r_hs;

  // bready/rready are only ever high in WR_RESP/RD_DATA, so they alone
  // qualify the completion handshakes.
  assign b_hs = bready_q && axi_ctrl_bvalid;
  assign r_hs = rready_q && axi_ctrl_rvalid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      ST_WR: begin
        // AW and W retire independently; leave once both have gone.
        if (awvalid_q && axi_ctrl_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_ctrl_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = 1'b1;
          rsp_data_d  = '0;
          rsp_resp_d  = axi_ctrl_bresp;
          state_d     = ST_RSP;
        end
      end

      ST_RD_ADDR: begin
        if (axi_ctrl_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = 1'b0;
          rsp_data_d  = axi_ctrl_rdata;
          rsp_resp_d  = axi_ctrl_rresp;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clear) begin
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      err_cnt_d = '0;
    end else begin
      if (b_hs) wr_cnt_d = wr_cnt_q + CNT_BITS'(1);
      if (r_hs) rd_cnt_d = rd_cnt_q + CNT_BITS'(1);
      if ((b_hs && (axi_ctrl_bresp != 2'b00)) || (r_hs && (axi_ctrl_rresp != 2'b00)))
        err_cnt_d = err_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready        = (state_q == ST_IDLE) && !areset;

  assign axi_ctrl_awaddr  = addr_q;
  assign axi_ctrl_awvalid = awvalid_q;
  assign axi_ctrl_wdata   = wdata_q;
  assign axi_ctrl_wstrb   = wstrb_q;
  assign axi_ctrl_wvalid  = wvalid_q;
  assign axi_ctrl_bready  = bready_q;
  assign axi_ctrl_araddr  = addr_q;
  assign axi_ctrl_arvalid = arvalid_q;
  assign axi_ctrl_rready  = rready_q;

  assign rsp_valid        = rsp_valid_q;
  assign rsp_wr           = rsp_wr_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_resp         = rsp_resp_q;

  assign wr_cnt           = wr_cnt_q;
  assign rd_cnt           = rd_cnt_q;
  assign err_cnt          = err_cnt_q;

endmodule
